// File: rtl/seg7_scan_ctrl.sv
// Round-robin scan controller feeding one shared seg7 decoder with four digits.
// Optional inter-digit blanking gap is enabled by defining SEG7_SCAN_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] digit,
  output logic [3:0] dig_en,
  output logic       frame_start
);

  localparam int unsigned NumDigits = 4;
  localparam int unsigned DigitW    = 4;
  localparam int unsigned IdxW      = 2;
  localparam int unsigned CntW      = 16;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535) begin : g_bad_dwell
    $error("seg7_scan_ctrl: DWELL_CYCLES must be 1..65535");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 65535) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

`ifdef SEG7_SCAN_BLANK_EN
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam state_e          RunEntry  = ST_BLANK;
`else
  localparam state_e          RunEntry  = ST_SHOW;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DigitW-1:0]   shadow_q [NumDigits];
  logic [DigitW-1:0]   shadow_d [NumDigits];
  logic [DigitW-1:0]   active_q [NumDigits];
  logic [DigitW-1:0]   active_d [NumDigits];
  logic [DigitW-1:0]   digit_q, digit_d;
  logic [NumDigits-1:0] dig_en_q, dig_en_d;
  logic                frame_start_q, frame_start_d;

  logic                run_ok;
  logic                commit;
  logic [IdxW-1:0]     first_idx;
  logic [IdxW-1:0]     next_idx;
  logic                next_found;
  logic [IdxW-1:0]     cand;

  assign run_ok = en && (digit_mask != '0);

  // Lowest enabled digit, and the next enabled digit above idx_q (wrapping).
  always_comb begin
    first_idx  = '0;
    next_idx   = idx_q;
    next_found = 1'b0;
    cand       = '0;
    for (int k = NumDigits - 1; k >= 0; k--) begin
      if (digit_mask[IdxW'(k)]) begin
        first_idx = IdxW'(k);
      end
    end
    for (int k = 1; k <= NumDigits; k++) begin
      cand = IdxW'(idx_q + IdxW'(k));
      if (!next_found && digit_mask[cand]) begin
        next_idx   = cand;
        next_found = 1'b1;
      end
    end
  end

  // Next-state, storage and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CntW'(1);
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit        = 1'b0;
    frame_start_d = 1'b0;
    dig_en_d      = '0;
    digit_d       = '0;

    if (wr_en) begin
      shadow_d[wr_addr] = wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (run_ok) begin
          state_d = RunEntry;
          idx_d   = first_idx;
          commit  = 1'b1;
        end
      end
`ifdef SEG7_SCAN_BLANK_EN
      ST_BLANK: begin
        if (!run_ok) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == BlankLast) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
`endif
      ST_SHOW: begin
        if (!run_ok) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == DwellLast) begin
          // Wrapping back to an equal or lower digit closes the frame.
          state_d = RunEntry;
          cnt_d   = '0;
          idx_d   = next_idx;
          commit  = (next_idx <= idx_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (commit) begin
      active_d      = shadow_d;
      frame_start_d = 1'b1;
    end

    if (state_d == ST_SHOW) begin
      dig_en_d = NumDigits'(1) << idx_d;
      digit_d  = active_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      digit_q       <= '0;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      digit_q       <= digit_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit       = digit_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

endmodule
